// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Run-controlled programmable serial pattern detector with
//               Mealy match strobe, match counter and completion target.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_we,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic [CNT_W-1:0]             cfg_target,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         x,
   input  logic                         x_valid,
   output logic                         z,
   output logic                         busy,
   output logic                         done,
   output logic [CNT_W-1:0]             match_count,
   output logic                         cfg_err
);

   localparam int                 c_len_w       = $clog2(MAX_LEN+1);
   localparam logic [c_len_w-1:0] c_max_len     = c_len_w'(MAX_LEN);
   localparam logic [c_len_w-1:0] c_def_len     = c_len_w'(4);
   localparam logic [MAX_LEN-1:0] c_def_pattern = MAX_LEN'(4'b1011);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_start_run;

   logic [MAX_LEN-1:0]   r_pattern;
   logic [c_len_w-1:0]   r_len;
   logic                 r_overlap;
   logic [CNT_W-1:0]     r_target;

   logic [MAX_LEN-2:0]   r_hist;
   logic [c_len_w-1:0]   r_fill;
   logic [CNT_W-1:0]     r_count;
   logic                 r_cfg_err;

   logic [MAX_LEN-1:0]   w_cand;
   logic [MAX_LEN-1:0]   w_mask;
   logic                 w_fill_ok;
   logic                 w_match;
   logic [CNT_W-1:0]     w_count_inc;
   logic                 w_len_ok;
   logic                 w_cfg_load;

   // Oldest history bits beyond the pattern length are masked off, so a
   // single full-width compare serves every length including len=1.
   assign w_cand      = {r_hist, x};
   assign w_mask      = ~({MAX_LEN{1'b1}} << r_len);
   assign w_fill_ok   = ({1'b0, r_fill} + 1'b1) >= {1'b0, r_len};
   assign w_match     = (r_state == S_RUN) && x_valid && w_fill_ok &&
                        (((w_cand ^ r_pattern) & w_mask) == '0);
   assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;
   assign w_len_ok    = (cfg_len != '0) && (cfg_len <= c_max_len);
   assign w_cfg_load  = cfg_we && (r_state != S_RUN) && w_len_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_run = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_start_run = 1'b1;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_match && (r_target != '0) && (w_count_inc == r_target)) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pattern <= c_def_pattern;
         r_len     <= c_def_len;
         r_overlap <= 1'b1;
         r_target  <= '0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_count   <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_we && ((r_state == S_RUN) || !w_len_ok);
         if (w_cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
         end
         if (w_start_run) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
         end else if ((r_state == S_RUN) && x_valid) begin
            r_hist <= w_cand[MAX_LEN-2:0];
            // Non-overlapping mode restarts only the fill gate; history keeps shifting.
            if (w_match && !r_overlap) begin
               r_fill <= '0;
            end else if (r_fill != c_max_len) begin
               r_fill <= r_fill + 1'b1;
            end
            if (w_match) begin
               r_count <= w_count_inc;
            end
         end
      end
   end

   assign z           = w_match;
   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign match_count = r_count;
   assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_ctrl
// Description : Directed and randomized bench for seq_det_ctrl against a
//               queue-based reference model of the detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int LEN_W   = $clog2(MAX_LEN+1);
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DONE  = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               cfg_we = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic [CNT_W-1:0]   cfg_target = '0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               x = 1'b0;
   logic               x_valid = 1'b0;
   logic               z;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   match_count;
   logic               cfg_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the valid bits seen since the run start (or since the
   // last non-overlapping match), compared against the pattern directly.
   int                 m_state;
   bit                 m_q[$];
   logic [MAX_LEN-1:0] m_pat;
   int                 m_len;
   bit                 m_ov;
   int                 m_tgt;
   int                 m_cnt;
   bit                 m_err;

   seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
      .start(start), .abort(abort), .x(x), .x_valid(x_valid), .z(z),
      .busy(busy), .done(done), .match_count(match_count), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state = M_IDLE;
      m_q.delete();
      m_pat   = MAX_LEN'(4'b1011);
      m_len   = 4;
      m_ov    = 1'b1;
      m_tgt   = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
   endfunction

   function automatic bit model_match();
      int  n;
      bit  b;
      if (m_state != M_RUN || !x_valid) return 1'b0;
      n = m_q.size() + 1;
      if (n < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         b = (i == m_len - 1) ? x : m_q[m_q.size() - (m_len - 1) + i];
         if (b != m_pat[m_len - 1 - i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_update(input bit hit);
      bit legal;
      if (reset) begin
         model_reset();
         return;
      end
      legal = (cfg_len != 0) && (int'(cfg_len) <= MAX_LEN);
      m_err = cfg_we && (m_state == M_RUN || !legal);
      if (cfg_we && m_state != M_RUN && legal) begin
         m_pat = cfg_pattern;
         m_len = int'(cfg_len);
         m_ov  = cfg_overlap;
         m_tgt = int'(cfg_target);
      end
      if (m_state != M_RUN) begin
         if (start) begin
            m_state = M_RUN;
            m_q.delete();
            m_cnt = 0;
         end
      end else begin
         if (x_valid) begin
            m_q.push_back(x);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            if (hit) begin
               if (m_cnt < CNT_MAX) m_cnt++;
               if (!m_ov) m_q.delete();
            end
         end
         if (abort) m_state = M_IDLE;
         else if (hit && m_tgt != 0 && m_cnt == m_tgt) m_state = M_DONE;
      end
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      bit ez;
      #1;
      ez = model_match();
      check("z", z, ez);
      check("busy", busy, m_state == M_RUN);
      check("done", done, m_state == M_DONE);
      check("match_count", match_count, m_cnt);
      check("cfg_err", cfg_err, m_err);
      @(posedge clk);
      model_update(ez);
      @(negedge clk);
      reset = 1'b0; cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
      x = 1'b0; x_valid = 1'b0;
   endtask

   task automatic do_cfg(input logic [MAX_LEN-1:0] pat, input int len, input bit ov,
                         input int tgt, input bit st);
      cfg_we = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len);
      cfg_overlap = ov; cfg_target = CNT_W'(tgt); start = st;
      tick();
   endtask

   task automatic send(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         x = bits[i]; x_valid = 1'b1;
         tick();
      end
   endtask

   initial begin
      @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("rst_count", match_count, 0);

      // Default config, overlapping 1011 over 1011011
      start = 1'b1; tick();
      send(16'b1011011, 7);
      check("dflt_count", match_count, 2);
      check("dflt_busy", busy, 1);

      abort = 1'b1; tick();
      do_cfg(8'b1011, 4, 1'b0, 0, 1'b1);
      send(16'b1011011, 7);
      check("novl_count", match_count, 1);

      abort = 1'b1; tick();
      do_cfg(8'b1011, 4, 1'b1, 2, 1'b1);
      send(16'b1011011, 7);
      check("tgt_done", done, 1);
      check("tgt_busy", busy, 0);
      check("tgt_count", match_count, 2);
      tick();
      start = 1'b1; tick();
      check("restart_done", done, 0);
      check("restart_count", match_count, 0);

      // Gap of invalid cycles inside a partial sequence
      abort = 1'b1; tick();
      do_cfg(8'b1011, 4, 1'b1, 0, 1'b1);
      send(16'b10, 2);
      tick(); tick(); tick();
      send(16'b11, 2);
      check("gap_count", match_count, 1);

      // Rejected writes: in RUN and illegal length
      cfg_we = 1'b1; cfg_len = LEN_W'(2); cfg_pattern = 8'b11; tick();
      check("err_run", cfg_err, 1);
      abort = 1'b1; tick();
      do_cfg(8'b0, 0, 1'b1, 0, 1'b0);
      check("err_len0", cfg_err, 1);
      start = 1'b1; tick();
      send(16'b1011, 4);
      check("post_err_count", match_count, 1);
      abort = 1'b1; tick();
      do_cfg(8'b1, 1, 1'b1, 0, 1'b1);
      send(16'b1101, 4);
      check("len1_count", match_count, 3);

      // Abort after 1,0,1 then reset mid-stream
      abort = 1'b1; tick();
      do_cfg(8'b1011, 4, 1'b1, 0, 1'b1);
      send(16'b101, 3);
      x = 1'b1; x_valid = 1'b1; abort = 1'b1; tick();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      start = 1'b1; tick();
      send(16'b10, 2);
      reset = 1'b1; tick();
      check("rst_mid_busy", busy, 0);
      check("rst_mid_count", match_count, 0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 99) < 5) begin
            cfg_we      = 1'b1;
            cfg_pattern = MAX_LEN'($urandom);
            cfg_len     = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
            if ($urandom_range(0, 3) != 0) cfg_len = LEN_W'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom);
            cfg_target  = CNT_W'($urandom_range(0, 4));
         end
         start   = ($urandom_range(0, 99) < 6);
         abort   = ($urandom_range(0, 99) < 2);
         reset   = ($urandom_range(0, 199) == 0);
         x       = 1'($urandom);
         x_valid = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
